fir_sample_sequencer: RTL and testbench
=======================================

// Module: fir_sample_sequencer
// PURPOSE
//   Sequences test/stream samples into the FIR datapath: walks a waveform ROM
//   (TABLE_LEN words, one signal period), issues ROM reads at a programmable
//   sample rate, aligns ROM read latency and drives the FIR sample strobe/data.
//   Sits between the waveform ROM and top_level (FIR); replaces free-running en.
// PARAMETERS
//   DATA_WIDTH   24   sample width (ROM word and FIR input)
//   ADDR_WIDTH   24   ROM address width
//   TABLE_LEN    440  ROM words per signal period (44000/100); >=2
//   DIV_WIDTH    16   width of sample-rate divider
//   ROM_LATENCY  1    ROM read latency in cycles (1..4)
// PORTS
//   i_clk           in   1           clock
//   i_rst_n         in   1           async active-low reset
//   i_start         in   1           1-cycle start pulse (ignored unless IDLE)
//   i_stop          in   1           1-cycle stop pulse (abort after drain)
//   iv_clk_div      in   DIV_WIDTH   cycles between samples minus 1; latched at start
//   iv_num_periods  in   8           periods to play; 0 = run until i_stop
//   i_fir_ready     in   1           FIR can accept a sample this tick
//   ov_rom_addr     out  ADDR_WIDTH  ROM read address
//   o_rom_en        out  1           ROM read enable (1 cycle per sample)
//   iv_rom_data     in   DATA_WIDTH  ROM read data
//   o_fir_en        out  1           FIR sample strobe (1 cycle)
//   ov_fir_din      out  DATA_WIDTH  FIR sample, valid with o_fir_en
//   o_busy          out  1           high in RUN or DRAIN
//   o_done          out  1           1-cycle pulse on completion/abort
//   ov_period_cnt   out  8           completed periods since start
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE, addr/tick/period counters 0, pipe empty.
//   - FSM IDLE -> RUN on i_start (latch div/num_periods; clear addr, counts).
//     RUN -> DRAIN on i_stop, or on period_cnt reaching num_periods (!=0).
//     DRAIN -> DONE when latency pipe empty; DONE -> IDLE next cycle (o_done=1).
//   - Tick gen: counter 0..div; tick when counter==div; div=0 => tick every cycle.
//     First tick occurs div+1 cycles after start is accepted.
//   - On tick in RUN with i_fir_ready=1: o_rom_en=1, ov_rom_addr=addr; addr
//     increments; at TABLE_LEN-1 wraps to 0 and period_cnt increments (sat 255).
//   - Tick with i_fir_ready=0: sample slot skipped, addr NOT advanced.
//   - Alignment: valid shift reg of depth ROM_LATENCY; when it emerges,
//     register iv_rom_data -> ov_fir_din and pulse o_fir_en next cycle.
//     Total latency o_rom_en -> o_fir_en = ROM_LATENCY+1 cycles.
//   - ov_fir_din holds last value between strobes; cleared only by reset.
//   - Simultaneous i_stop and tick in RUN: stop wins, no ROM read issued.
//   - Last read of final period is issued; DRAIN delivers all in-flight reads.
//   - i_start in RUN/DRAIN/DONE ignored; i_stop in IDLE/DONE ignored.
//   - i_start and i_stop same cycle in IDLE: start accepted, stop ignored.
//   - Async reset mid-operation: immediate return to reset state, in-flight dropped.
// CONFIGURATION
//   FIR_SEQ_OVERRUN_CNT_EN defined: adds output ov_overrun_cnt [15:0], counts
//   RUN ticks skipped due to i_fir_ready=0; saturates at 0xFFFF; cleared on
//   start. Undefined: port and counter absent; skip behaviour unchanged.
// STRUCTURE
//   fir_seq_pkg: state enum (IDLE,RUN,DRAIN,DONE), MAX_ROM_LATENCY=4,
//   PERIOD_CNT_W=8, OVERRUN_CNT_W=16.
//   Sub-module fir_seq_tick_gen: divider counter with enable/clear -> o_tick.
// TESTING
//   1) div=0, periods=1, ready=1: 440 o_rom_en pulses addr 0..439, 440 o_fir_en,
//      first o_fir_en 3 cycles after start (lat=1), o_done after last, cnt=1.
//   2) div=3: o_rom_en exactly every 4 cycles; ov_fir_din equals ROM[addr].
//   3) periods=2: addr wraps 439->0, ov_period_cnt 0->1->2, then o_done.
//   4) periods=0, i_stop at addr 100 same cycle as tick: no read at 100,
//      in-flight samples delivered, o_done pulses, o_busy falls.
//   5) i_fir_ready=0 for 5 ticks: addr held; overrun_cnt=5 if macro set.
//   6) i_rst_n low mid-RUN: all outputs 0 same cycle; restart begins at addr 0.

Source files
------------

// File: rtl/fir_seq_pkg.sv
// ============================================================================
// Module   : fir_seq_pkg
// Brief    : Shared types and constants for the FIR sample sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int MAX_ROM_LATENCY = 4;
  localparam int PERIOD_CNT_W    = 8;
  localparam int OVERRUN_CNT_W   = 16;

  // Period counter sticks at all-ones instead of wrapping.
  function automatic logic [PERIOD_CNT_W-1:0] period_sat_inc(
    input logic [PERIOD_CNT_W-1:0] cnt
  );
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_seq_tick_gen.sv
// ============================================================================
// Module   : fir_seq_tick_gen
// Brief    : Sample-rate divider; counts 0..div and ticks on the terminal count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_seq_tick_gen
  import fir_seq_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_clr,
  input  logic [DIV_WIDTH-1:0] iv_div,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 w_at_div;

  assign w_at_div = (r_cnt == iv_div);
  assign o_tick   = i_en & w_at_div;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_div ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fir_sample_sequencer.sv
// ============================================================================
// Module   : fir_sample_sequencer
// Brief    : Walks a waveform ROM at a programmable rate and feeds the FIR.
//            FIR_SEQ_OVERRUN_CNT_EN adds ov_overrun_cnt (skipped RUN ticks).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_sample_sequencer
  import fir_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int ADDR_WIDTH  = 24,
  parameter int TABLE_LEN   = 440,
  parameter int DIV_WIDTH   = 16,
  parameter int ROM_LATENCY = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic [DIV_WIDTH-1:0]     iv_clk_div,
  input  logic [PERIOD_CNT_W-1:0]  iv_num_periods,
  input  logic                     i_fir_ready,
  output logic [ADDR_WIDTH-1:0]    ov_rom_addr,
  output logic                     o_rom_en,
  input  logic [DATA_WIDTH-1:0]    iv_rom_data,
  output logic                     o_fir_en,
  output logic [DATA_WIDTH-1:0]    ov_fir_din,
  output logic                     o_busy,
  output logic                     o_done,
`ifdef FIR_SEQ_OVERRUN_CNT_EN
  output logic [OVERRUN_CNT_W-1:0] ov_overrun_cnt,
`endif
  output logic [PERIOD_CNT_W-1:0]  ov_period_cnt
);

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(TABLE_LEN - 1);

  if (ROM_LATENCY < 1 || ROM_LATENCY > MAX_ROM_LATENCY) begin : g_bad_latency
    $error("fir_sample_sequencer: ROM_LATENCY out of range");
  end

  seq_state_t              r_state;
  seq_state_t              w_state_nxt;
  logic [DIV_WIDTH-1:0]    r_div;
  logic [PERIOD_CNT_W-1:0] r_num_periods;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [PERIOD_CNT_W-1:0] r_period_cnt;
  logic [PERIOD_CNT_W-1:0] w_period_inc;
  logic [ROM_LATENCY-1:0]  r_vpipe;
  logic                    r_fir_en;
  logic [DATA_WIDTH-1:0]   r_fir_din;
  logic                    w_tick;
  logic                    w_tick_en;
  logic                    w_start_acc;
  logic                    w_rom_en;
  logic                    w_addr_wrap;
  logic                    w_last_read;
  logic                    w_pipe_empty;

  assign w_tick_en    = (r_state == RUN);
  assign w_addr_wrap  = (r_addr == c_last_addr);
  assign w_period_inc = r_period_cnt + 1'b1;
  // The read that closes the final period is still issued; RUN ends with it.
  assign w_last_read  = w_addr_wrap && (r_num_periods != '0) &&
                        (w_period_inc == r_num_periods);
  assign w_pipe_empty = (r_vpipe == '0) && !r_fir_en;

  fir_seq_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_tick_en),
    .i_clr   (w_start_acc),
    .iv_div  (r_div),
    .o_tick  (w_tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_rom_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_start_acc = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // A stop coinciding with a tick suppresses that tick's read.
        if (i_stop) begin
          w_state_nxt = DRAIN;
        end else if (w_tick && i_fir_ready) begin
          w_rom_en = 1'b1;
          if (w_last_read) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_pipe_empty) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div         <= '0;
      r_num_periods <= '0;
      r_addr        <= '0;
      r_period_cnt  <= '0;
    end else if (w_start_acc) begin
      r_div         <= iv_clk_div;
      r_num_periods <= iv_num_periods;
      r_addr        <= '0;
      r_period_cnt  <= '0;
    end else if (w_rom_en) begin
      if (w_addr_wrap) begin
        r_addr       <= '0;
        r_period_cnt <= period_sat_inc(r_period_cnt);
      end else begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  // Valid marker travels alongside the ROM access so data is captured on arrival.
  if (ROM_LATENCY == 1) begin : g_pipe_one
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_vpipe <= '0;
      end else begin
        r_vpipe <= w_rom_en;
      end
    end
  end else begin : g_pipe_deep
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_vpipe <= '0;
      end else begin
        r_vpipe <= {r_vpipe[ROM_LATENCY-2:0], w_rom_en};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fir_en  <= 1'b0;
      r_fir_din <= '0;
    end else begin
      r_fir_en <= r_vpipe[ROM_LATENCY-1];
      if (r_vpipe[ROM_LATENCY-1]) begin
        r_fir_din <= iv_rom_data;
      end
    end
  end

`ifdef FIR_SEQ_OVERRUN_CNT_EN
  logic [OVERRUN_CNT_W-1:0] r_overrun_cnt;
  logic                     w_skip;

  assign w_skip = (r_state == RUN) && w_tick && !i_fir_ready && !i_stop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overrun_cnt <= '0;
    end else if (w_start_acc) begin
      r_overrun_cnt <= '0;
    end else if (w_skip && (r_overrun_cnt != '1)) begin
      r_overrun_cnt <= r_overrun_cnt + 1'b1;
    end
  end

  assign ov_overrun_cnt = r_overrun_cnt;
`endif

  assign ov_rom_addr   = r_addr;
  assign o_rom_en      = w_rom_en;
  assign o_fir_en      = r_fir_en;
  assign ov_fir_din    = r_fir_din;
  assign o_busy        = (r_state == RUN) || (r_state == DRAIN);
  assign o_done        = (r_state == DONE);
  assign ov_period_cnt = r_period_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fir_sample_sequencer.sv
// ============================================================================
// Module   : tb_fir_sample_sequencer
// Brief    : Scoreboard bench for fir_sample_sequencer with a latency-1 ROM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_sample_sequencer;

  localparam int TABLE_LEN = 440;

  logic        tb_clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] clk_div;
  logic [7:0]  num_periods;
  logic        fir_ready;
  logic [23:0] rom_addr;
  logic        rom_en;
  logic [23:0] rom_data;
  logic        fir_en;
  logic [23:0] fir_din;
  logic        busy;
  logic        done;
  logic [7:0]  period_cnt;
`ifdef FIR_SEQ_OVERRUN_CNT_EN
  logic [15:0] overrun_cnt;
`endif

  always #5 tb_clk = ~tb_clk;

  fir_sample_sequencer dut (
    .i_clk          (tb_clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_stop         (stop),
    .iv_clk_div     (clk_div),
    .iv_num_periods (num_periods),
    .i_fir_ready    (fir_ready),
    .ov_rom_addr    (rom_addr),
    .o_rom_en       (rom_en),
    .iv_rom_data    (rom_data),
    .o_fir_en       (fir_en),
    .ov_fir_din     (fir_din),
    .o_busy         (busy),
    .o_done         (done),
`ifdef FIR_SEQ_OVERRUN_CNT_EN
    .ov_overrun_cnt (overrun_cnt),
`endif
    .ov_period_cnt  (period_cnt)
  );

  function automatic logic [23:0] rom_val(input int a);
    return 24'((a * 40503 + 17) ^ (a << 7));
  endfunction

  // Registered ROM: one cycle of read latency.
  always @(posedge tb_clk) rom_data <= rom_val(int'(rom_addr));

  int cyc = 0;
  always @(posedge tb_clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] data;
    int          cyc;
  } sb_t;
  sb_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int exp_addr = 0;
  int exp_per  = 0;
  int exp_gap  = 0;
  int rom_cnt  = 0;
  int fir_cnt  = 0;
  int done_cnt = 0;
  int start_cyc, first_rom_cyc, last_rom_cyc, first_fir_cyc, last_fir_cyc, done_cyc;
  bit seen_rom, seen_fir;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge tb_clk);
      if (!rst_n) begin
        sb_q.delete();
        exp_addr = 0;
        exp_per  = 0;
      end else begin
        if (start && !busy && !done) begin
          exp_addr  = 0;
          exp_per   = 0;
          start_cyc = cyc;
          seen_rom  = 0;
          seen_fir  = 0;
        end
        if (rom_en) begin
          check("rom_addr", rom_addr, exp_addr);
          if (exp_addr == 0) check("period_cnt", period_cnt, exp_per);
          if (seen_rom && exp_gap != 0) check("rom_gap", cyc - last_rom_cyc, exp_gap);
          if (!seen_rom) first_rom_cyc = cyc;
          seen_rom     = 1;
          last_rom_cyc = cyc;
          e.data = rom_val(exp_addr);
          e.cyc  = cyc;
          sb_q.push_back(e);
          rom_cnt++;
          if (exp_addr == TABLE_LEN - 1) begin
            exp_addr = 0;
            exp_per++;
          end else begin
            exp_addr++;
          end
        end
        if (fir_en) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", sb_q.size(), 1);
          end else begin
            e = sb_q.pop_front();
            check("fir_din", fir_din, e.data);
            check("fir_lat", cyc - e.cyc, 2);
          end
          if (!seen_fir) first_fir_cyc = cyc;
          seen_fir     = 1;
          last_fir_cyc = cyc;
          fir_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  endtask

  task automatic start_run(input int div, input int per, input bit with_stop);
    @(posedge tb_clk); #1;
    clk_div     = 16'(div);
    num_periods = 8'(per);
    start       = 1'b1;
    stop        = with_stop;
    @(posedge tb_clk); #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge tb_clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check("done_seen", seen, 1);
    check("busy_in_done", busy, 0);
    @(negedge tb_clk);
    check("done_pulse", done, 0);
    check("sb_drained", sb_q.size(), 0);
  endtask

  int rom0, fir0, done0;
  bit hit;

  task automatic snap();
    rom0  = rom_cnt;
    fir0  = fir_cnt;
    done0 = done_cnt;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    clk_div = '0; num_periods = '0; fir_ready = 1'b1;
    fork monitor(); join_none
    #1;
    check("rst_rom_en", rom_en, 0);
    check("rst_fir_en", fir_en, 0);
    check("rst_fir_din", fir_din, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_period", period_cnt, 0);
    repeat (3) @(posedge tb_clk);
    #1 rst_n = 1'b1;

    // 1) one period at full rate; start with a simultaneous stop (stop ignored)
    exp_gap = 1; snap();
    start_run(0, 1, 1'b1);
    wait_done(600);
    check("t1_rom_cnt", rom_cnt - rom0, TABLE_LEN);
    check("t1_fir_cnt", fir_cnt - fir0, TABLE_LEN);
    check("t1_first_rom", first_rom_cyc - start_cyc, 1);
    check("t1_first_fir", first_fir_cyc - start_cyc, 3);
    check("t1_done_after_last", done_cyc > last_fir_cyc, 1);
    check("t1_done_cnt", done_cnt - done0, 1);
    check("t1_period_cnt", period_cnt, 1);

    // 2) divider of 3: a read every 4 cycles
    exp_gap = 4; snap();
    start_run(3, 1, 1'b0);
    wait_done(2000);
    check("t2_rom_cnt", rom_cnt - rom0, TABLE_LEN);
    check("t2_first_rom", first_rom_cyc - start_cyc, 4);
    check("t2_fir_cnt", fir_cnt - fir0, TABLE_LEN);

    // 3) two periods with address wrap
    exp_gap = 1; snap();
    start_run(0, 2, 1'b0);
    wait_done(1100);
    check("t3_rom_cnt", rom_cnt - rom0, 2 * TABLE_LEN);
    check("t3_period_cnt", period_cnt, 2);
    check("t3_done_cnt", done_cnt - done0, 1);

    // 4) free run, start ignored mid-RUN, stop on the tick at address 100
    exp_gap = 1; snap(); hit = 0;
    start_run(0, 0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      @(posedge tb_clk); #1;
      start = (rom_addr == 24'd50);
      if (rom_addr == 24'd100) begin
        stop = 1'b1;
        hit  = 1;
        break;
      end
    end
    check("t4_reach_100", hit, 1);
    @(posedge tb_clk); #1;
    start = 1'b0; stop = 1'b0;
    wait_done(50);
    check("t4_rom_cnt", rom_cnt - rom0, 100);
    check("t4_fir_cnt", fir_cnt - fir0, 100);
    check("t4_busy", busy, 0);

    // 5) FIR not ready for five ticks (div=1)
    exp_gap = 0; snap(); hit = 0;
    start_run(1, 0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(posedge tb_clk); #1;
      if (rom_addr == 24'd10) begin
        hit = 1;
        break;
      end
    end
    check("t5_reach_10", hit, 1);
    fir_ready = 1'b0;
    begin
      int r_before;
      r_before = rom_cnt;
      repeat (10) @(posedge tb_clk);
      #1;
      check("t5_no_reads", rom_cnt - r_before, 0);
      check("t5_addr_held", rom_addr, 10);
    end
    fir_ready = 1'b1;
    repeat (4) @(posedge tb_clk);
    #1 stop = 1'b1;
    @(posedge tb_clk); #1 stop = 1'b0;
    wait_done(50);
    check("t5_addr_end", rom_addr, 12);
    check("t5_fir_eq_rom", fir_cnt - fir0, rom_cnt - rom0);
`ifdef FIR_SEQ_OVERRUN_CNT_EN
    check("t5_overrun", overrun_cnt, 5);
`endif

    // 6) asynchronous reset mid-RUN, then a clean restart
    exp_gap = 1; hit = 0;
    start_run(0, 0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(posedge tb_clk); #1;
      if (rom_addr == 24'd50) begin
        hit = 1;
        break;
      end
    end
    check("t6_reach_50", hit, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rom_en", rom_en, 0);
    check("t6_fir_en", fir_en, 0);
    check("t6_fir_din", fir_din, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_addr", rom_addr, 0);
    check("t6_period", period_cnt, 0);
    repeat (3) @(posedge tb_clk);
    #1 rst_n = 1'b1;
    snap();
    start_run(0, 1, 1'b0);
    wait_done(600);
    check("t6_rom_cnt", rom_cnt - rom0, TABLE_LEN);
    check("t6_fir_cnt", fir_cnt - fir0, TABLE_LEN);
    check("t6_first_rom", first_rom_cyc - start_cyc, 1);

    repeat (3) @(posedge tb_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
